// File: rtl/lab3_cache_batch_mem_responder.sv
// ---------------------------------------------------------------------------
// lab3_cache_batch_mem_responder
//
// Purpose:
//   Memory-side end of the cache's batch line-transfer interface. A whole-line
//   read (refill) or write (writeback/flush) request is split into LINE_WORDS
//   in-order word requests on a 32-bit word memory port. Read data is
//   reassembled into a single line beat returned to the cache.
//
// Configuration macro:
//   BATCH_MEM_WRITE_ACK_EN - when defined, a completed write line produces one
//   response beat with all-zero data. When undefined, write lines complete
//   silently and the line response channel carries read data only.
//
// Ports:
//   clk, reset               clock; asynchronous active-low reset
//   batch_req_*              line request in (val/rdy, rw, addr, data)
//   batch_resp_*             line response out (val/rdy, data)
//   memreq_*                 word request out (val/rdy, type, addr, data)
//   memresp_*                word response in (val/rdy, data)
//   state_dbg                current FSM state: 0 IDLE, 1 ISSUE, 2 DRAIN, 3 RESP
//
// Handshake rule (all four channels): a transfer happens on a rising clock
// edge where both val and rdy are 1. The sender holds val and its payload
// stable until that edge; val never depends combinationally on rdy.
// ---------------------------------------------------------------------------
module lab3_cache_batch_mem_responder #(
   parameter int LINE_WORDS = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     batch_req_val,
   output logic                     batch_req_rdy,
   input  logic                     batch_req_rw,
   input  logic [31:0]              batch_req_addr,
   input  logic [32*LINE_WORDS-1:0] batch_req_data,
   output logic                     batch_resp_val,
   input  logic                     batch_resp_rdy,
   output logic [32*LINE_WORDS-1:0] batch_resp_data,
   output logic                     memreq_val,
   input  logic                     memreq_rdy,
   output logic                     memreq_type,
   output logic [31:0]              memreq_addr,
   output logic [31:0]              memreq_data,
   input  logic                     memresp_val,
   output logic                     memresp_rdy,
   input  logic [31:0]              memresp_data,
   output logic [1:0]               state_dbg
);

   localparam int IW  = $clog2(LINE_WORDS);
   localparam int CW  = IW + 1;
   localparam int OFS = IW + 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                    state;
   logic                      rw;
   logic [31:0]               base;
   logic [32*LINE_WORDS-1:0]  line;
   logic [CW-1:0]             issue_cnt;
   logic [CW-1:0]             resp_cnt;

   logic                      issue_fire;
   logic                      issue_last;
   logic                      resp_fire;
   logic [CW-1:0]             resp_cnt_nxt;
   logic                      resp_done;
   logic [IW-1:0]             issue_idx;
   logic [IW-1:0]             resp_idx;
   logic                      unused_addr_bits;

   // Offset bits inside the line are discarded when the base is latched.
   assign unused_addr_bits = ^batch_req_addr[OFS-1:0];

   assign issue_idx    = issue_cnt[IW-1:0];
   assign resp_idx     = resp_cnt[IW-1:0];
   assign issue_fire   = memreq_val && memreq_rdy;
   assign issue_last   = (issue_cnt == CW'(LINE_WORDS - 1));
   assign resp_fire    = memresp_val && memresp_rdy;
   // Counting the response accepted this cycle lets DRAIN finish on the
   // same edge that takes the final word.
   assign resp_cnt_nxt = resp_cnt + CW'(resp_fire);
   assign resp_done    = (resp_cnt_nxt == CW'(LINE_WORDS));

   // Base is line aligned, so adding the word offset never carries into
   // the tag bits except for the intended mod-2^32 wrap.
   assign memreq_type     = rw;
   assign memreq_addr     = base + {{(32-OFS){1'b0}}, issue_idx, 2'b00};
   assign memreq_data     = line[{issue_idx, 5'b00000} +: 32];
   assign batch_resp_data = line;
   assign state_dbg       = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         rw             <= 1'b0;
         base           <= '0;
         line           <= '0;
         issue_cnt      <= '0;
         resp_cnt       <= '0;
         batch_req_rdy  <= 1'b0;
         batch_resp_val <= 1'b0;
         memreq_val     <= 1'b0;
         memresp_rdy    <= 1'b0;
      end else begin
         // Responses are in order, so resp_cnt names the slot to fill.
         // Issued slots are always ahead of filled slots, so a read response
         // never clobbers a word that still has to be sent.
         if (resp_fire) begin
            resp_cnt <= resp_cnt_nxt;
            if (!rw) begin
               line[{resp_idx, 5'b00000} +: 32] <= memresp_data;
            end
         end

         case (state)
            IDLE: begin
               // Ready rises one cycle after reset release and then stays
               // high until a request is taken.
               batch_req_rdy <= 1'b1;
               if (batch_req_val && batch_req_rdy) begin
                  rw            <= batch_req_rw;
                  base          <= {batch_req_addr[31:OFS], {OFS{1'b0}}};
                  line          <= batch_req_data;
                  issue_cnt     <= '0;
                  resp_cnt      <= '0;
                  batch_req_rdy <= 1'b0;
                  memreq_val    <= 1'b1;
                  memresp_rdy   <= 1'b1;
                  state         <= ISSUE;
               end
            end

            ISSUE: begin
               if (issue_fire) begin
                  issue_cnt <= issue_cnt + CW'(1);
                  if (issue_last) begin
                     memreq_val <= 1'b0;
                     state      <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               if (resp_done) begin
                  memresp_rdy <= 1'b0;
                  if (!rw) begin
                     batch_resp_val <= 1'b1;
                     state          <= RESP;
                  end else begin
`ifdef BATCH_MEM_WRITE_ACK_EN
                     // Write acknowledge carries an all-zero line.
                     line           <= '0;
                     batch_resp_val <= 1'b1;
                     state          <= RESP;
`else
                     issue_cnt      <= '0;
                     resp_cnt       <= '0;
                     batch_req_rdy  <= 1'b1;
                     state          <= IDLE;
`endif
                  end
               end
            end

            RESP: begin
               if (batch_resp_rdy) begin
                  batch_resp_val <= 1'b0;
                  batch_req_rdy  <= 1'b1;
                  issue_cnt      <= '0;
                  resp_cnt       <= '0;
                  state          <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
